host_lm_ulm_master: RTL and testbench
=====================================

HOST_LM_ULM_MASTER -- requirements
Module: host_lm_ulm_master

Interface
REQ-001 Parameters SHALL be: GPIO_W, 32, GPIO data word width; CNT_W, 16, word-count width; TIMEOUT_CYCLES, 1024, handshake watchdog limit.
REQ-002 The clock and reset ports SHALL be: Clk  in  1  clock; ResetN  in  1  reset, asynchronous, active-low.
REQ-003 Control ports SHALL be: xfer_start_i  in  1  begin transfer; dir_i  in  1  0=load into BRAM, 1=unload from BRAM; num_words_i  in  CNT_W  word count; xfer_ready_o  out  1  idle; words_done_o  out  CNT_W  completed words; err_o  out  1  sticky timeout error.
REQ-004 Stream ports SHALL be: src_valid_i  in  1; src_data_i  in  GPIO_W; src_ready_o  out  1 (load words); snk_valid_o  out  1; snk_data_o  out  GPIO_W; snk_ready_i  in  1 (unload words).
REQ-005 Protocol ports SHALL be: lm_stopped_i  in  1  device handshake (device has stopped, waiting); lm_continue_o  out  1  host handshake; lm_done_o  out  1  final-word flag; gpio_data_o  out  GPIO_W  data to device; gpio_data_i  in  GPIO_W  data from device.

Function
REQ-006 Block SHALL be the host end of the load/unload BRAM handshake: it drives continue/done/data toward the device controller and consumes its stopped/out-word.
REQ-007 States SHALL be IDLE, WAIT_STOP, XFER_WORD, ASSERT_CONT, WAIT_RELEASE, FINISH.
REQ-008 In IDLE, xfer_ready_o=1; xfer_start_i=1 SHALL latch dir_i and num_words_i, clear words_done_o, go to WAIT_STOP next cycle; start while not IDLE SHALL be ignored.
REQ-009 num_words_i=0 at start SHALL go IDLE->FINISH with no protocol activity.
REQ-010 WAIT_STOP SHALL wait for lm_stopped_i=1, then enter XFER_WORD.
REQ-011 XFER_WORD, load: src_ready_o=1; on src_valid_i=1, src_data_i SHALL be registered onto gpio_data_o and state ASSERT_CONT next cycle.
REQ-012 XFER_WORD, unload: on entry gpio_data_i SHALL be captured into snk_data_o with snk_valid_o=1, held until snk_ready_i=1, then ASSERT_CONT.
REQ-013 ASSERT_CONT SHALL drive lm_continue_o=1, and lm_done_o=1 iff words_done_o==latched count-1; gpio_data_o SHALL be stable while lm_continue_o=1.
REQ-014 ASSERT_CONT SHALL hold until lm_stopped_i=0, then enter WAIT_RELEASE with lm_continue_o=0, lm_done_o=0, words_done_o incremented.
REQ-015 From WAIT_RELEASE: words_done_o==count -> FINISH; else WAIT_STOP.
REQ-016 FINISH SHALL last exactly one cycle then return to IDLE (xfer_ready_o=1 the following cycle).
REQ-017 lm_continue_o and src_ready_o/snk_valid_o SHALL never be high simultaneously.
REQ-018 words_done_o SHALL saturate at count; no wrap.

Reset
REQ-019 ResetN=0 SHALL asynchronously force IDLE, xfer_ready_o=1, all other outputs 0, from any state mid-transfer.
REQ-020 err_o SHALL clear only on reset or on an accepted xfer_start_i.

Configuration
REQ-021 With HOST_LM_ULM_TIMEOUT_EN defined, a counter SHALL clear on every state change and, on reaching TIMEOUT_CYCLES in WAIT_STOP or ASSERT_CONT, set err_o=1, drop lm_continue_o/lm_done_o, go to IDLE.
REQ-022 Without HOST_LM_ULM_TIMEOUT_EN, no counter SHALL exist, err_o SHALL be tied 0, waits SHALL be unbounded.

Structure
REQ-023 State encoding, direction constants (DIR_LOAD=0, DIR_UNLOAD=1) and default widths SHALL live in shared package host_xfer_pkg.
REQ-024 Watchdog SHALL be sub-module host_xfer_wdt (clear, enable, expired); FSM, counters and data registers in the top.

Verification
REQ-025 Load 3 words 0xA5A5_0001..3 against a device model -> three continue pulses, lm_done_o only with 3rd, words_done_o=3, xfer_ready_o back high.
REQ-026 Unload 2 words, device presents 0x1234_5678 then 0xDEAD_BEEF, snk_ready_i held low 5 cycles -> snk_data_o matches in order, continue not raised until snk_ready_i.
REQ-027 num_words_i=0 -> lm_continue_o never high, FINISH one cycle, xfer_ready_o high 2 cycles after start.
REQ-028 ResetN low during ASSERT_CONT of word 2 of 4 -> lm_continue_o=0 immediately, xfer_ready_o=1, words_done_o=0.
REQ-029 TIMEOUT_EN, TIMEOUT_CYCLES=16, lm_stopped_i stuck 1 after continue -> err_o=1 after 16 cycles, IDLE; next start clears err_o.
REQ-030 xfer_start_i pulsed mid-transfer -> ignored; latched count and dir unchanged.

Source files
------------

// File: rtl/host_xfer_pkg.sv
`default_nettype none
// ============================================================================
//  Module : host_xfer_pkg
//  Brief  : Shared state encoding, direction codes and default widths for the
//           host load/unload BRAM handshake master.
//  Rev    : 1.0  initial release
// ============================================================================
package host_xfer_pkg;

   localparam int DEF_GPIO_W         = 32;
   localparam int DEF_CNT_W          = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   localparam logic DIR_LOAD   = 1'b0;
   localparam logic DIR_UNLOAD = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_WAIT_STOP    = 3'd1,
      ST_XFER_WORD    = 3'd2,
      ST_ASSERT_CONT  = 3'd3,
      ST_WAIT_RELEASE = 3'd4,
      ST_FINISH       = 3'd5
   } xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/host_xfer_wdt.sv
`default_nettype none
// ============================================================================
//  Module : host_xfer_wdt
//  Brief  : Handshake watchdog; counts enabled cycles since the last clear and
//           flags expiry on the LIMIT-th cycle.
//  Rev    : 1.0  initial release
// ============================================================================
module host_xfer_wdt
   import host_xfer_pkg::*;
#(
   parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + W'(1);
      end
   end

   // cnt holds the number of completed cycles in the state, so LIMIT-1 is the last one
   assign expired = enable && (cnt == W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/host_lm_ulm_master.sv
`default_nettype none
// ============================================================================
//  Module : host_lm_ulm_master
//  Brief  : Host end of the load/unload BRAM handshake (continue/done/data out,
//           stopped/data in). Optional watchdog: define HOST_LM_ULM_TIMEOUT_EN.
//  Rev    : 1.0  initial release
// ============================================================================
module host_lm_ulm_master
   import host_xfer_pkg::*;
#(
   parameter int GPIO_W         = DEF_GPIO_W,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              Clk,
   input  logic              ResetN,
   input  logic              xfer_start_i,
   input  logic              dir_i,
   input  logic [CNT_W-1:0]  num_words_i,
   output logic              xfer_ready_o,
   output logic [CNT_W-1:0]  words_done_o,
   output logic              err_o,
   input  logic              src_valid_i,
   input  logic [GPIO_W-1:0] src_data_i,
   output logic              src_ready_o,
   output logic              snk_valid_o,
   output logic [GPIO_W-1:0] snk_data_o,
   input  logic              snk_ready_i,
   input  logic              lm_stopped_i,
   output logic              lm_continue_o,
   output logic              lm_done_o,
   output logic [GPIO_W-1:0] gpio_data_o,
   input  logic [GPIO_W-1:0] gpio_data_i
);

   xfer_state_t      state, state_next;
   logic             dir;
   logic [CNT_W-1:0] count;
   logic             start_ok;
   logic             wdt_expired;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   assign start_ok = (state == ST_IDLE) && xfer_start_i;

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) state <= ST_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next    = state;
      xfer_ready_o  = 1'b0;
      src_ready_o   = 1'b0;
      lm_continue_o = 1'b0;
      lm_done_o     = 1'b0;
      case (state)
         ST_IDLE: begin
            xfer_ready_o = 1'b1;
            if (xfer_start_i)
               state_next = (num_words_i == '0) ? ST_FINISH : ST_WAIT_STOP;
         end
         ST_WAIT_STOP: begin
            if (wdt_expired)       state_next = ST_IDLE;
            else if (lm_stopped_i) state_next = ST_XFER_WORD;
         end
         ST_XFER_WORD: begin
            if (dir == DIR_LOAD) begin
               src_ready_o = 1'b1;
               if (src_valid_i) state_next = ST_ASSERT_CONT;
            end else if (snk_valid_o && snk_ready_i) begin
               state_next = ST_ASSERT_CONT;
            end
         end
         ST_ASSERT_CONT: begin
            lm_continue_o = 1'b1;
            lm_done_o     = (words_done_o == count - CNT_W'(1));
            if (wdt_expired)        state_next = ST_IDLE;
            else if (!lm_stopped_i) state_next = ST_WAIT_RELEASE;
         end
         ST_WAIT_RELEASE: begin
            state_next = (words_done_o == count) ? ST_FINISH : ST_WAIT_STOP;
         end
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         dir          <= DIR_LOAD;
         count        <= '0;
         words_done_o <= '0;
         gpio_data_o  <= '0;
         snk_data_o   <= '0;
         snk_valid_o  <= 1'b0;
      end else begin
         if (start_ok) begin
            dir          <= dir_i;
            count        <= num_words_i;
            words_done_o <= '0;
         end
         if (state == ST_XFER_WORD && dir == DIR_LOAD && src_valid_i)
            gpio_data_o <= src_data_i;
         // unload word is sampled on the same edge the device's stop is seen
         if (state == ST_WAIT_STOP && state_next == ST_XFER_WORD && dir == DIR_UNLOAD) begin
            snk_data_o  <= gpio_data_i;
            snk_valid_o <= 1'b1;
         end else if (snk_valid_o && snk_ready_i) begin
            snk_valid_o <= 1'b0;
         end
         if (state == ST_ASSERT_CONT && state_next == ST_WAIT_RELEASE && words_done_o != count)
            words_done_o <= words_done_o + CNT_W'(1);
      end
   end

`ifdef HOST_LM_ULM_TIMEOUT_EN
   logic err;

   host_xfer_wdt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdt (
      .clk     (Clk),
      .rst_n   (ResetN),
      .clear   (state_next != state),
      .enable  ((state == ST_WAIT_STOP) || (state == ST_ASSERT_CONT)),
      .expired (wdt_expired)
   );

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN)          err <= 1'b0;
      else if (start_ok)    err <= 1'b0;
      else if (wdt_expired) err <= 1'b1;
   end

   assign err_o = err;
`else
   assign wdt_expired = 1'b0;
   assign err_o       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_host_lm_ulm_master.sv
`default_nettype none
// ============================================================================
//  Module : tb_host_lm_ulm_master
//  Brief  : Self-checking bench; device, source and sink modelled per word.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_host_lm_ulm_master;

   logic        Clk = 1'b0;
   logic        ResetN;
   logic        xfer_start_i, dir_i;
   logic [15:0] num_words_i;
   logic        xfer_ready_o, err_o;
   logic [15:0] words_done_o;
   logic        src_valid_i, src_ready_o, snk_valid_o, snk_ready_i;
   logic [31:0] src_data_i, snk_data_o, gpio_data_o, gpio_data_i;
   logic        lm_stopped_i, lm_continue_o, lm_done_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] ld_words[$];
   logic [31:0] ul_words[$];

   host_lm_ulm_master #(
      .GPIO_W(32), .CNT_W(16), .TIMEOUT_CYCLES(16)
   ) dut (
      .Clk(Clk), .ResetN(ResetN),
      .xfer_start_i(xfer_start_i), .dir_i(dir_i), .num_words_i(num_words_i),
      .xfer_ready_o(xfer_ready_o), .words_done_o(words_done_o), .err_o(err_o),
      .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
      .snk_valid_o(snk_valid_o), .snk_data_o(snk_data_o), .snk_ready_i(snk_ready_i),
      .lm_stopped_i(lm_stopped_i), .lm_continue_o(lm_continue_o), .lm_done_o(lm_done_o),
      .gpio_data_o(gpio_data_o), .gpio_data_i(gpio_data_i)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic fill(input int n);
      ld_words.delete();
      ul_words.delete();
      for (int i = 0; i < n; i++) begin
         ld_words.push_back($urandom);
         ul_words.push_back($urandom);
      end
   endtask

   // One transfer of n words. rdy_hold<0 means random sink readiness;
   // rst_at/stuck_at name the continue pulse (1-based) to reset at or never release.
   task automatic run_xfer(input logic d, input int n, input int rdy_hold,
                           input int rst_at, input int stuck_at, input bit poke);
      int src_idx = 0, snk_idx = 0, conts = 0, cyc = 0, rise_cyc = 0, dly, wait_cnt = 0;
      bit dev_stop = 0, stuck = 0, prev_cont = 0, sv_prev = 0;
      logic [31:0] held = '0;
      dir_i = d; num_words_i = 16'(n); xfer_start_i = 1'b1;
      src_valid_i = 1'b0; snk_ready_i = 1'b0; lm_stopped_i = 1'b0;
      dly = $urandom_range(0, 3);
      step();
      xfer_start_i = 1'b0; dir_i = ~d; num_words_i = 16'($urandom);
      chk("ready_low_after_start", xfer_ready_o, 0);
      chk("words_done_cleared", words_done_o, 0);
      chk("err_cleared_on_start", err_o, 0);
      while (!xfer_ready_o && cyc < 400) begin
         chk("cont_exclusive", lm_continue_o && (src_ready_o || snk_valid_o), 0);
         chk("done_only_with_cont", lm_done_o && !lm_continue_o, 0);
         if (lm_continue_o && !prev_cont) begin
            conts++; rise_cyc = cyc; held = gpio_data_o;
            chk("words_before_cont", (d == 1'b0) ? src_idx : snk_idx, conts);
            if (d == 1'b0 && conts <= n) chk("gpio_data", gpio_data_o, ld_words[conts-1]);
            chk("lm_done_last_only", lm_done_o, conts == n);
            chk("words_done_at_cont", words_done_o, conts - 1);
            if (conts == rst_at) begin
               ResetN = 1'b0;
               #1;
               chk("rst_cont", lm_continue_o, 0);
               chk("rst_done", lm_done_o, 0);
               chk("rst_ready", xfer_ready_o, 1);
               chk("rst_words", words_done_o, 0);
               chk("rst_gpio", gpio_data_o, 0);
               chk("rst_streams", {src_ready_o, snk_valid_o, err_o}, 0);
               lm_stopped_i = 1'b0; src_valid_i = 1'b0; snk_ready_i = 1'b0;
               step();
               ResetN = 1'b1;
               step();
               return;
            end
            if (conts == stuck_at) stuck = 1;
            dly = $urandom_range(0, 3);
         end
         if (lm_continue_o) chk("gpio_stable", gpio_data_o, held);
         prev_cont = lm_continue_o;
         // device model
         if (dev_stop && lm_continue_o && !stuck) begin
            if (dly == 0) begin dev_stop = 0; lm_stopped_i = 1'b0; dly = $urandom_range(0, 3); end
            else dly--;
         end else if (!dev_stop && !lm_continue_o && conts < n) begin
            if (dly == 0) begin
               dev_stop = 1; lm_stopped_i = 1'b1;
               gpio_data_i = ul_words[conts];
               dly = $urandom_range(0, 3);
            end else dly--;
         end
         // source
         src_valid_i = ($urandom_range(0, 2) != 0);
         src_data_i  = (src_idx < n) ? ld_words[src_idx] : $urandom;
         if (src_ready_o && src_valid_i) src_idx++;
         // sink
         if (snk_valid_o) begin
            if (!sv_prev) wait_cnt = 0;
            chk("snk_in_range", snk_idx < n, 1);
            if (snk_idx < n) chk("snk_data", snk_data_o, ul_words[snk_idx]);
            snk_ready_i = (rdy_hold >= 0) ? (wait_cnt >= rdy_hold) : 1'($urandom_range(0, 1));
            wait_cnt++;
            if (snk_ready_i) snk_idx++;
         end else begin
            snk_ready_i = 1'($urandom_range(0, 1));
         end
         sv_prev = snk_valid_o;
         xfer_start_i = poke && (cyc == 2);
         if (poke && cyc == 2) begin dir_i = ~d; num_words_i = 16'(n + 3); end
         step();
         xfer_start_i = 1'b0;
         cyc++;
      end
      lm_stopped_i = 1'b0; src_valid_i = 1'b0; snk_ready_i = 1'b0;
      chk("xfer_completes", xfer_ready_o, 1);
      if (stuck) begin
         chk("timeout_latency", cyc - rise_cyc, 16);
         chk("timeout_err", err_o, 1);
         chk("timeout_words", words_done_o, stuck_at - 1);
         chk("timeout_cont_low", lm_continue_o, 0);
         return;
      end
      if (n == 0) chk("zero_finish_1cyc", cyc, 1);
      chk("words_done_final", words_done_o, n);
      chk("cont_pulses", conts, n);
      chk("words_moved", (d == 1'b0) ? src_idx : snk_idx, n);
      chk("err_low", err_o, 0);
   endtask

   initial begin
      ResetN = 1'b0; xfer_start_i = 1'b0; dir_i = 1'b0; num_words_i = '0;
      src_valid_i = 1'b0; src_data_i = '0; snk_ready_i = 1'b0;
      lm_stopped_i = 1'b0; gpio_data_i = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_ready", xfer_ready_o, 1);
      chk("reset_outs", {lm_continue_o, lm_done_o, src_ready_o, snk_valid_o, err_o}, 0);
      chk("reset_words", words_done_o, 0);
      chk("reset_data", {gpio_data_o, snk_data_o}, 0);
      ResetN = 1'b1;
      step();

      fill(3);
      ld_words[0] = 32'hA5A5_0001; ld_words[1] = 32'hA5A5_0002; ld_words[2] = 32'hA5A5_0003;
      run_xfer(1'b0, 3, -1, 0, 0, 0);

      fill(2);
      ul_words[0] = 32'h1234_5678; ul_words[1] = 32'hDEAD_BEEF;
      run_xfer(1'b1, 2, 5, 0, 0, 0);

      run_xfer(1'b0, 0, -1, 0, 0, 0);

      fill(4);
      run_xfer(1'b0, 4, -1, 2, 0, 0);

      fill(3);
      run_xfer(1'b1, 3, -1, 0, 0, 1);

      for (int k = 0; k < 6; k++) begin
         int nw;
         nw = $urandom_range(1, 6);
         fill(nw);
         run_xfer(1'($urandom_range(0, 1)), nw, -1, 0, 0, 0);
      end

`ifdef HOST_LM_ULM_TIMEOUT_EN
      fill(3);
      run_xfer(1'b0, 3, -1, 0, 2, 0);
      run_xfer(1'b0, 0, -1, 0, 0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
